// File: rtl/assoc_pkg.sv
// Shared state encoding and width constants for the association neuron.
package assoc_pkg;

    localparam int ASSOC_W_WIDTH = 12;
    localparam int ASSOC_P_WIDTH = ASSOC_W_WIDTH + 1;

    localparam logic [ASSOC_W_WIDTH-1:0] WEIGHT_MAX = '1;
    localparam logic [ASSOC_P_WIDTH-1:0] POT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        REFRACT = 2'd2
    } state_e;

endpackage

// File: rtl/spike_window.sv
// Rising-edge detector for one detector enable plus its coincidence-window down-counter.
module spike_window #(
    parameter int COINC_WINDOW = 1040
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    input  logic clear_i,
    output logic rise_o,
    output logic active_o
);

    localparam int CW = $clog2(COINC_WINDOW + 1);
    localparam logic [CW-1:0] LOAD = CW'(COINC_WINDOW);

    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign rise_o = in_i & ~prev_q;

    // The load cycle counts as the first window cycle, so a partner rise
    // up to COINC_WINDOW-1 cycles later still lands inside the window.
    assign active_o = (cnt_q > CW'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (rise_o) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= in_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/association_neuron.sv
// Leaky integrate-and-fire output neuron that learns the bell synapse by food/bell coincidence.
// Optional feature: define ASSOC_DECAY_EN for slow extinction of an unpaired bell weight.
module association_neuron
    import assoc_pkg::*;
#(
    parameter int                 W_WIDTH        = ASSOC_W_WIDTH,
    parameter logic [W_WIDTH-1:0] S1_WEIGHT      = 12'hFFF,
    parameter logic [W_WIDTH-1:0] S2_INIT        = 12'h000,
    parameter logic [W_WIDTH:0]   THRESHOLD      = 13'h0800,
    parameter logic [W_WIDTH-1:0] LEARN_STEP     = 12'h040,
    parameter int                 COINC_WINDOW   = 1040,
    parameter int                 LEAK_PERIOD    = 1024,
    parameter logic [W_WIDTH:0]   LEAK_STEP      = 13'h0010,
    parameter int                 REFRACT_CYCLES = 104
) (
    input  logic               CLK104MHZ,
    input  logic               CPU_RESETN,
    input  logic               N1S1_OUT,
    input  logic               N2S2_OUT,
    output logic               fire_out,
    output logic [W_WIDTH-1:0] s2_weight,
    output logic [W_WIDTH:0]   potential,
    output logic               learned
);

    localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RW = $clog2(REFRACT_CYCLES + 2);
    localparam logic [W_WIDTH:0]   POT_SAT = {(W_WIDTH + 1){1'b1}};
    localparam logic [W_WIDTH-1:0] W_SAT   = {W_WIDTH{1'b1}};

    state_e             state_q, state_d;
    logic [RW-1:0]      refr_q, refr_d;
    logic [LW-1:0]      leak_q;
    logic               leak_tick;
    logic [W_WIDTH:0]   pot_q, pot_d, pot_sum;
    logic [W_WIDTH+1:0] sum_full;
    logic [W_WIDTH-1:0] s2_q, s2_d;
    logic [W_WIDTH:0]   s2_inc;
    logic               learned_q;
    logic               rise1, rise2, act1, act2, pairing;

    spike_window #(.COINC_WINDOW(COINC_WINDOW)) u_food (
        .clk_i    (CLK104MHZ),
        .rst_ni   (CPU_RESETN),
        .in_i     (N1S1_OUT),
        .clear_i  (pairing),
        .rise_o   (rise1),
        .active_o (act1)
    );

    spike_window #(.COINC_WINDOW(COINC_WINDOW)) u_bell (
        .clk_i    (CLK104MHZ),
        .rst_ni   (CPU_RESETN),
        .in_i     (N2S2_OUT),
        .clear_i  (pairing),
        .rise_o   (rise2),
        .active_o (act2)
    );

    assign pairing   = (rise1 & rise2) | (rise1 & act2) | (rise2 & act1);
    assign leak_tick = (leak_q == LW'(LEAK_PERIOD - 1));

    // Extra top bit of sum_full catches overflow beyond the potential range.
    always_comb begin
        sum_full = {1'b0, pot_q};
        if (rise1) sum_full = sum_full + {2'b00, S1_WEIGHT};
        if (rise2) sum_full = sum_full + {2'b00, s2_q};
        pot_sum = sum_full[W_WIDTH+1] ? POT_SAT : sum_full[W_WIDTH:0];
    end

    always_comb begin
        pot_d = pot_q;
        case (state_q)
            IDLE: begin
                if (rise1 | rise2) begin
                    pot_d = pot_sum;
                end else if (leak_tick) begin
                    pot_d = (pot_q >= LEAK_STEP) ? (pot_q - LEAK_STEP) : '0;
                end
            end
            FIRE:    pot_d = '0;
            default: pot_d = pot_q;
        endcase
    end

`ifdef ASSOC_DECAY_EN
    logic [19:0] decay_q;
    logic        decay_tick;

    assign decay_tick = (&decay_q) & ~pairing;

    always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            decay_q <= '0;
        end else if (pairing) begin
            decay_q <= '0;
        end else begin
            decay_q <= decay_q + 20'd1;
        end
    end
`endif

    assign s2_inc = {1'b0, s2_q} + {1'b0, LEARN_STEP};

    always_comb begin
        s2_d = s2_q;
`ifdef ASSOC_DECAY_EN
        if (decay_tick && (s2_q > S2_INIT)) s2_d = s2_q - W_WIDTH'(1);
`endif
        if (pairing) s2_d = s2_inc[W_WIDTH] ? W_SAT : s2_inc[W_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        refr_d  = refr_q;
        case (state_q)
            IDLE: begin
                if (pot_q >= THRESHOLD) state_d = FIRE;
            end
            FIRE: begin
                refr_d  = RW'(REFRACT_CYCLES);
                state_d = (REFRACT_CYCLES == 0) ? IDLE : REFRACT;
            end
            REFRACT: begin
                if (refr_q != '0) refr_d = refr_q - RW'(1);
                if (refr_q <= RW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fire_out = (state_q == FIRE);
    end

    always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q   <= IDLE;
            refr_q    <= '0;
            leak_q    <= '0;
            pot_q     <= '0;
            s2_q      <= S2_INIT;
            learned_q <= ({1'b0, S2_INIT} >= THRESHOLD);
        end else begin
            state_q   <= state_d;
            refr_q    <= refr_d;
            leak_q    <= leak_tick ? '0 : (leak_q + LW'(1));
            pot_q     <= pot_d;
            s2_q      <= s2_d;
            learned_q <= ({1'b0, s2_d} >= THRESHOLD);
        end
    end

    assign s2_weight = s2_q;
    assign potential = pot_q;
    assign learned   = learned_q;

endmodule

// File: tb/tb_association_neuron.sv
// Scoreboard bench for association_neuron: stimulus queues expected fire pulses, a monitor checks them.
`timescale 1ns/1ps
module tb_association_neuron;

    logic        clk  = 1'b0;
    logic        rstN = 1'b0;
    logic        n1   = 1'b0;
    logic        n2   = 1'b0;
    logic        fireOut;
    logic [11:0] s2Weight;
    logic [12:0] potential;
    logic        learned;

    typedef struct {
        int          cyc;
        logic [11:0] weight;
    } fireExp_t;

    fireExp_t expQ[$];
    fireExp_t monExp;
    int       cyc      = 0;
    int       asserts  = 0;
    int       failures = 0;
    int       gaps[3]  = '{2000, 1040, 1039};
    int       gapW[3]  = '{0, 0, 'h040};

    association_neuron dut (
        .CLK104MHZ  (clk),
        .CPU_RESETN (rstN),
        .N1S1_OUT   (n1),
        .N2S2_OUT   (n2),
        .fire_out   (fireOut),
        .s2_weight  (s2Weight),
        .potential  (potential),
        .learned    (learned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        asserts++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushFire(input int c, input int wgt);
        fireExp_t e;
        e.cyc    = c;
        e.weight = wgt[11:0];
        expQ.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-edge-wide pulse; t returns the edge number that samples the rise.
    task automatic applyStimulus(input logic p1, input logic p2, output int t);
        n1 = p1;
        n2 = p2;
        waitCycles(1);
        t  = cyc;
        n1 = 1'b0;
        n2 = 1'b0;
    endtask

    task automatic resetDut();
        checkOutput("pending_fires", expQ.size(), 0);
        expQ.delete();
        rstN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n1 = i[0];
            n2 = i[1];
            waitCycles(1);
        end
        checkOutput("reset_fire", fireOut, 0);
        checkOutput("reset_potential", potential, 0);
        checkOutput("reset_weight", s2Weight, 0);
        checkOutput("reset_learned", learned, 0);
        n1 = 1'b0;
        n2 = 1'b0;
        waitCycles(1);
        rstN = 1'b1;
        waitCycles(2);
    endtask

    // Every fire pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (fireOut) begin
            if (expQ.size() == 0) begin
                asserts++;
                failures++;
                $display("[TB] FAIL unexpected_fire: pulse at cycle %0d, expected none", cyc);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("fire_cycle", cyc, monExp.cyc);
                checkOutput("fire_weight", s2Weight, monExp.weight);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, t0, wi, refrEnd;
        waitCycles(2);

        $display("[TB] reset and single food spike");
        resetDut();
        applyStimulus(1'b1, 1'b0, t0);
        checkOutput("n1_potential", potential, 'h0FFF);
        pushFire(t0 + 1, 0);
        waitCycles(49);
        applyStimulus(1'b1, 1'b0, t);
        checkOutput("refract_ignore", potential, 0);
        waitCycles(t0 + 106 - cyc);
        applyStimulus(1'b1, 1'b0, t);
        checkOutput("post_refract_potential", potential, 'h0FFF);
        pushFire(t + 1, 0);
        waitCycles(130);
        checkOutput("n1_no_learning", s2Weight, 0);

        $display("[TB] lone bell with initial weight");
        resetDut();
        applyStimulus(1'b0, 1'b1, t);
        checkOutput("n2_alone_potential", potential, 0);
        waitCycles(200);
        checkOutput("n2_alone_weight", s2Weight, 0);
        checkOutput("n2_alone_potential_late", potential, 0);

        $display("[TB] coincidence window edges");
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, t);
            waitCycles(gaps[i] - 1);
            applyStimulus(1'b1, 1'b0, t);
            checkOutput("window_weight", s2Weight, gapW[i]);
            pushFire(t + 1, gapW[i]);
            waitCycles(1200);
        end

        $display("[TB] simultaneous rises and leak");
        resetDut();
        applyStimulus(1'b1, 1'b1, t);
        checkOutput("simul_potential", potential, 'h0FFF);
        checkOutput("simul_weight", s2Weight, 'h040);
        checkOutput("simul_learned", learned, 0);
        pushFire(t + 1, 'h040);
        waitCycles(130);
        applyStimulus(1'b0, 1'b1, t);
        checkOutput("n2_weighted_potential", potential, 'h040);
        waitCycles(5200);
        checkOutput("leak_to_zero", potential, 0);
        checkOutput("lone_n2_no_learning", s2Weight, 'h040);

        $display("[TB] 32 delayed pairings");
        resetDut();
        wi = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, t);
            checkOutput("pair_n2_potential", potential, wi);
            waitCycles(499);
            applyStimulus(1'b1, 1'b0, t);
            wi = wi + 'h40;
            checkOutput("pair_weight", s2Weight, wi);
            checkOutput("pair_learned", learned, (wi >= 'h800) ? 1 : 0);
            pushFire(t + 1, wi);
            waitCycles(130);
        end
        checkOutput("learned_weight", s2Weight, 'h800);
        checkOutput("learned_flag", learned, 1);
        applyStimulus(1'b0, 1'b1, t);
        checkOutput("learned_n2_potential", potential, 'h800);
        pushFire(t + 1, 'h800);
        waitCycles(130);

        $display("[TB] saturation and reset during refractory");
        resetDut();
        wi      = 0;
        refrEnd = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b1, t);
            wi = wi + 64;
            if (wi > 4095) wi = 4095;
            if (t >= refrEnd) begin
                pushFire(t + 1, wi);
                refrEnd = t + 107;
            end
            waitCycles(1);
        end
        waitCycles(130);
        checkOutput("sat_weight", s2Weight, 'hFFF);
        checkOutput("sat_learned", learned, 1);
        applyStimulus(1'b1, 1'b0, t);
        pushFire(t + 1, 'hFFF);
        waitCycles(10);
        #2 rstN = 1'b0;
        #1;
        checkOutput("refract_reset_fire", fireOut, 0);
        checkOutput("refract_reset_potential", potential, 0);
        checkOutput("refract_reset_weight", s2Weight, 0);
        checkOutput("refract_reset_learned", learned, 0);
        waitCycles(2);
        rstN = 1'b1;
        waitCycles(2);
        checkOutput("pending_fires", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/association_neuron.md
# association_neuron

Post-synaptic output neuron of the classical-conditioning ANN, sitting directly downstream of the two-detector `Neuron` stage and consuming its `N1S1_OUT` (sight of food) and `N2S2_OUT` (ring of bell) enables. It integrates weighted input spikes into a leaky membrane potential, emits a one-cycle `fire_out` pulse (salivation) on crossing threshold, and learns the bell synapse weight by Hebbian coincidence. The food synapse weight is fixed; the bell synapse weight starts low and grows with each food/bell pairing.

## Interface
- `W_WIDTH`, 12, synapse weight width
- `S1_WEIGHT`, 12'hFFF, fixed food synapse weight
- `S2_INIT`, 12'h000, bell weight after reset
- `THRESHOLD`, 13'h0800, firing threshold on potential
- `LEARN_STEP`, 12'h040, bell weight increment per pairing
- `COINC_WINDOW`, 1040, coincidence window in cycles (10 us)
- `LEAK_PERIOD`, 1024, cycles between leak decrements
- `LEAK_STEP`, 13'h0010, potential decrement per leak tick
- `REFRACT_CYCLES`, 104, refractory length in cycles
- `CLK104MHZ` in 1, sole clock, rising edge
- `CPU_RESETN` in 1, reset, asynchronous, active-low
- `N1S1_OUT` in 1, food detector enable, level, same clock domain
- `N2S2_OUT` in 1, bell detector enable, level, same clock domain
- `fire_out` out 1, one-cycle firing pulse
- `s2_weight` out W_WIDTH, current learned bell weight
- `potential` out W_WIDTH+1, membrane potential
- `learned` out 1, high while `s2_weight >= THRESHOLD`

## Operation
- Reset: `fire_out`=0, `potential`=0, `s2_weight`=S2_INIT, `learned`=(S2_INIT>=THRESHOLD), state IDLE, window/leak/refractory counters 0, edge registers 0.
- Inputs edge-detected against registered previous value; only rising edges count. A level held high is one spike.
- States: IDLE, FIRE, REFRACT.
- IDLE: on N1 rise add S1_WEIGHT; on N2 rise add current (pre-update) `s2_weight`; both in one cycle add both. Sum saturates at 13'h1FFF. Leak tick (leak counter wraps at LEAK_PERIOD-1, free-running in all states) subtracts LEAK_STEP, floor 0, only in cycles with no addition. `potential >= THRESHOLD` (registered value) -> FIRE.
- FIRE (one cycle): `fire_out`=1, `potential`<=0, refractory counter <= REFRACT_CYCLES -> REFRACT; if REFRACT_CYCLES=0 -> IDLE directly.
- REFRACT: input spikes not integrated, no leak; counter decrements; at 1 -> IDLE.
- Learning (all states): each rise loads its window counter with COINC_WINDOW; counter decrements to 0. A rise on one input while the other's window is nonzero, or simultaneous rises, is a pairing: `s2_weight` += LEARN_STEP saturating at all-ones; both windows cleared that cycle. One increment per pairing.
- `learned` is registered, updated with `s2_weight`.

## Timing
- Rise sampled at edge t -> `potential` updated at edge t.
- `potential` first >= THRESHOLD at edge t -> `fire_out` high for edge t+1 to t+2 only.
- Pairing detected at edge t -> `s2_weight`, `learned` updated at edge t; new weight used from next spike.
- Window: second rise at most COINC_WINDOW-1 cycles after first counts; later does not.
- Reset assertion mid-any-state returns immediately to reset values; learned weight is lost.

## Configuration
- `ASSOC_DECAY_EN` defined: `s2_weight` decrements by 1 (floor S2_INIT) every 2^20 cycles with no pairing in that interval (extinction); interval counter resets on each pairing.
- Undefined: `s2_weight` only changes by pairing or reset; decay logic absent.

## Structure
- Package `assoc_pkg`: state enum (IDLE/FIRE/REFRACT), `W_WIDTH`, potential width, saturation max constants.
- One sub-module `spike_window`: rise detect plus COINC_WINDOW down-counter with clear input; outputs `rise`, `active`; instantiated once per input.

## Test plan
- Reset held low with inputs toggling -> `fire_out`=0, `potential`=0, `s2_weight`=0, `learned`=0.
- Single N1 pulse at t -> `potential`=0x0FFF at t, `fire_out` one pulse at t+1, `potential`=0, 104-cycle refractory ignores an N1 pulse at t+50.
- N2 pulse alone with default weight -> `potential` stays 0, no fire, no weight change.
- N2 rise then N1 rise 500 cycles later -> `s2_weight`=0x040; 32 such pairings -> 0x800, `learned`=1; then lone N2 -> `fire_out` pulse.
- N2 rise then N1 rise 2000 cycles later -> `s2_weight` unchanged; simultaneous N1/N2 rises -> one increment only.
- 300 pairings -> `s2_weight` saturates at 0xFFF; `CPU_RESETN` low during REFRACT -> all outputs reset same cycle.
